// File: rtl/calc_pkg.sv
// Shared types for the calculator command sequencer: opcodes, flag width,
// FSM states and the opcode legality check.
`timescale 1ns/1ps
package calc_pkg;

  localparam int unsigned FLAG_W = 3;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_AND   = 4'h2,
    OP_OR    = 4'h3,
    OP_XOR   = 4'h4,
    OP_INC   = 4'h5,
    OP_DEC   = 4'h6,
    OP_NOT   = 4'h7,
    OP_NEG   = 4'h8,
    OP_SHL   = 4'h9,
    OP_SHR   = 4'hA,
    OP_RSV_B = 4'hB,
    OP_RSV_C = 4'hC,
    OP_MIN   = 4'hD,
    OP_MAX   = 4'hE,
    OP_EQU   = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_GO,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Opcodes 0xB and 0xC have no calculator function and are discarded.
  function automatic logic is_legal_op(input logic [3:0] op);
    return !((op == OP_RSV_B) || (op == OP_RSV_C));
  endfunction

endpackage

// File: rtl/calc_cmd_seq_if.sv
// Command and response handshake bundle of the sequencer.
`timescale 1ns/1ps
interface calc_cmd_seq_if;
  import calc_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [7:0]        cmd_operand;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [3:0]        rsp_op;
  logic [7:0]        rsp_result;
  logic [FLAG_W-1:0] rsp_flags;

  // Sequencer side: accepts commands, produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_flags
  );

  // Environment side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_result, rsp_flags
  );
endinterface

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO, power-of-two depth, registered occupancy.
`timescale 1ns/1ps
module calc_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointers and occupancy; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/calc_cmd_seq.sv
// Queues calculator commands and steps each through setup, execute strobe,
// settle and response hand-off, one command in flight at a time.
`timescale 1ns/1ps
module calc_cmd_seq
  import calc_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  calc_cmd_seq_if.slave          bus,
  output logic [7:0]             calc_operand,
  output logic [3:0]             calc_op,
  output logic                   calc_go,
  input  logic [7:0]             calc_result,
  input  logic [FLAG_W-1:0]      calc_flags,
  output logic                   bad_op,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic [11:0]       fifo_head;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [3:0]        head_op;
  logic [7:0]        head_operand;

  state_e            state_q;
  logic [1:0]        wait_cnt_q;
  logic [3:0]        calc_op_q;
  logic [7:0]        calc_operand_q;
  logic              calc_go_q;
  logic              bad_op_q;
  logic              rsp_valid_q;
  logic [3:0]        rsp_op_q;
  logic [7:0]        rsp_result_q;
  logic [FLAG_W-1:0] rsp_flags_q;

  assign head_op      = fifo_head[11:8];
  assign head_operand = fifo_head[7:0];
  assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty;

  calc_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (12)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.cmd_valid),
    .push_data_i ({bus.cmd_op, bus.cmd_operand}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bus.cmd_ready  = !fifo_full;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign calc_op        = calc_op_q;
  assign calc_operand   = calc_operand_q;
  assign calc_go        = calc_go_q;
  assign bad_op         = bad_op_q;

  // Command sequencing FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= '0;
      calc_op_q      <= '0;
      calc_operand_q <= '0;
      calc_go_q      <= 1'b0;
      bad_op_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_op_q       <= '0;
      rsp_result_q   <= '0;
      rsp_flags_q    <= '0;
    end else begin
      bad_op_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (is_legal_op(head_op)) begin
              calc_op_q      <= head_op;
              calc_operand_q <= head_operand;
              state_q        <= ST_SETUP;
            end else begin
              bad_op_q <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          calc_go_q <= 1'b1;
          state_q   <= ST_GO;
        end
        ST_GO: begin
          calc_go_q  <= 1'b0;
          wait_cnt_q <= 2'(SETTLE - 1);
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            rsp_op_q     <= calc_op_q;
            rsp_result_q <= calc_result;
            rsp_flags_q  <= calc_flags;
            rsp_valid_q  <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_seq.sv
// Directed bench for calc_cmd_seq (DEPTH=4, SETTLE=1) with a simple
// calculator model that updates its result only on the execute strobe.
`timescale 1ns/1ps
module tb_calc_cmd_seq;
  import calc_pkg::*;

  logic              clk;
  logic              rst;
  logic [7:0]        calc_operand;
  logic [3:0]        calc_op;
  logic              calc_go;
  logic [7:0]        calc_result;
  logic [FLAG_W-1:0] calc_flags;
  logic              bad_op;
  logic [2:0]        fifo_count;

  int errors = 0;
  int checks = 0;

  calc_cmd_seq_if bus ();

  calc_cmd_seq #(
    .DEPTH  (4),
    .SETTLE (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .calc_operand (calc_operand),
    .calc_op      (calc_op),
    .calc_go      (calc_go),
    .calc_result  (calc_result),
    .calc_flags   (calc_flags),
    .bad_op       (bad_op),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_res(input logic [3:0] op, input logic [7:0] opd);
    return opd ^ 8'hA5 ^ {op, 4'h0};
  endfunction

  function automatic logic [2:0] exp_flg(input logic [3:0] op);
    return op[2:0] ^ 3'b101;
  endfunction

  // Calculator model: result changes only on the edge that ends the strobe cycle.
  initial begin
    calc_result = 8'h00;
    calc_flags  = 3'b000;
  end
  always @(posedge clk) begin
    if (calc_go) begin
      calc_result <= exp_res(calc_op, calc_operand);
      calc_flags  <= exp_flg(calc_op);
    end
  end

  // Observation at the falling edge: strobes, discards, completed responses.
  int          cyc = 0;
  int          go_count = 0;
  int          go_double = 0;
  int          bad_count = 0;
  int          go_cycles[$];
  logic [14:0] rsp_q[$];
  logic        prev_go = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (calc_go) begin
      go_count++;
      go_cycles.push_back(cyc);
      if (prev_go) go_double++;
    end
    prev_go = calc_go;
    if (bad_op) bad_count++;
    if (bus.rsp_valid && bus.rsp_ready && !rst)
      rsp_q.push_back({bus.rsp_op, bus.rsp_result, bus.rsp_flags});
  end

  task automatic clear_mon();
    go_count  = 0;
    bad_count = 0;
    go_cycles.delete();
    rsp_q.delete();
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] opd);
    int t;
    @(posedge clk); #1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_operand = opd;
    t = 0;
    while (!bus.cmd_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_accept op=%0h got cmd_ready=%b exp=1", op, bus.cmd_ready);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int t = 0; t < 300 && rsp_q.size() < n; t++) @(negedge clk);
    checks++;
    if (rsp_q.size() != n) begin
      errors++;
      $display("FAIL rsp_count got=%0d exp=%0d", rsp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_operand = '0; bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_fifo_count got=%0d exp=0", fifo_count); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (calc_go !== 1'b0) begin errors++; $display("FAIL rst_calc_go got=%b exp=0", calc_go); end
    checks++; if (calc_op !== 4'h0 || calc_operand !== 8'h00) begin errors++; $display("FAIL rst_calc_regs got=%0h/%0h exp=0/0", calc_op, calc_operand); end
    checks++; if (bad_op !== 1'b0) begin errors++; $display("FAIL rst_bad_op got=%b exp=0", bad_op); end
    checks++; if ({bus.rsp_op, bus.rsp_result, bus.rsp_flags} !== 15'h0) begin errors++; $display("FAIL rst_rsp_fields got=%0h exp=0", {bus.rsp_op, bus.rsp_result, bus.rsp_flags}); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ADD 0x01 from idle: strobe in the cycle after edge 2, response after edge 4.
  task automatic test_single();
    clear_mon();
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'h0; bus.cmd_operand = 8'h01;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count0 got=%0d exp=1", fifo_count); end
    for (int e = 1; e <= 5; e++) begin
      @(negedge clk);
      checks++;
      if (calc_go !== (e == 2)) begin errors++; $display("FAIL single_go edge=%0d got=%b exp=%b", e, calc_go, (e == 2)); end
      checks++;
      if (bus.rsp_valid !== (e == 4)) begin errors++; $display("FAIL single_rsp_valid edge=%0d got=%b exp=%b", e, bus.rsp_valid, (e == 4)); end
      if (e == 1) begin
        checks++;
        if (calc_op !== 4'h0 || calc_operand !== 8'h01) begin errors++; $display("FAIL single_load got=%0h/%0h exp=0/01", calc_op, calc_operand); end
      end
      if (e == 4) begin
        checks++;
        if ({bus.rsp_op, bus.rsp_result, bus.rsp_flags} !== {4'h0, exp_res(4'h0, 8'h01), exp_flg(4'h0)}) begin
          errors++;
          $display("FAIL single_rsp got=%0h exp=%0h", {bus.rsp_op, bus.rsp_result, bus.rsp_flags}, {4'h0, exp_res(4'h0, 8'h01), exp_flg(4'h0)});
        end
      end
    end
    checks++; if (calc_operand !== 8'h01) begin errors++; $display("FAIL single_hold got=%0h exp=01", calc_operand); end
    checks++; if (go_count != 1) begin errors++; $display("FAIL single_go_count got=%0d exp=1", go_count); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3] = '{4'h0, 4'h1, 4'h4};
    logic [7:0] opds[3] = '{8'h01, 8'h0F, 8'h55};
    clear_mon();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(ops[i], opds[i]);
    wait_rsp(3);
    for (int i = 0; i < 3 && i < rsp_q.size(); i++) begin
      checks++;
      if (rsp_q[i] !== {ops[i], exp_res(ops[i], opds[i]), exp_flg(ops[i])}) begin
        errors++;
        $display("FAIL b2b_rsp%0d got=%0h exp=%0h", i, rsp_q[i], {ops[i], exp_res(ops[i], opds[i]), exp_flg(ops[i])});
      end
    end
    checks++; if (go_count != 3) begin errors++; $display("FAIL b2b_go_count got=%0d exp=3", go_count); end
    for (int i = 1; i < go_cycles.size(); i++) begin
      checks++;
      if (go_cycles[i] - go_cycles[i-1] < 5) begin errors++; $display("FAIL b2b_go_gap got=%0d exp>=5", go_cycles[i] - go_cycles[i-1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ops [5] = '{4'h2, 4'h3, 4'h5, 4'h6, 4'h7};
    logic [7:0] opds[5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    clear_mon();
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_cmd(ops[i], opds[i]);
    repeat (4) @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_count got=%0d exp=4", fifo_count); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready got=%b exp=0", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_op !== 4'h2) begin errors++; $display("FAIL bp_hold got=%b/%0h exp=1/2", bus.rsp_valid, bus.rsp_op); end
    checks++; if (go_count != 1) begin errors++; $display("FAIL bp_go_count got=%0d exp=1", go_count); end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    wait_rsp(5);
    for (int i = 0; i < 5 && i < rsp_q.size(); i++) begin
      checks++;
      if (rsp_q[i] !== {ops[i], exp_res(ops[i], opds[i]), exp_flg(ops[i])}) begin
        errors++;
        $display("FAIL bp_rsp%0d got=%0h exp=%0h", i, rsp_q[i], {ops[i], exp_res(ops[i], opds[i]), exp_flg(ops[i])});
      end
    end
  endtask

  task automatic test_bad_op();
    clear_mon();
    bus.rsp_ready = 1'b1;
    push_cmd(4'hB, 8'h33);
    push_cmd(4'h8, 8'h44);
    wait_rsp(1);
    repeat (4) @(negedge clk);
    checks++; if (bad_count != 1) begin errors++; $display("FAIL bad_pulses got=%0d exp=1", bad_count); end
    checks++; if (go_count != 1) begin errors++; $display("FAIL bad_go_count got=%0d exp=1", go_count); end
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0] !== {4'h8, exp_res(4'h8, 8'h44), exp_flg(4'h8)}) begin
      errors++;
      $display("FAIL bad_rsp got=%0h n=%0d exp=%0h", (rsp_q.size() > 0) ? rsp_q[0] : 15'h0, rsp_q.size(), {4'h8, exp_res(4'h8, 8'h44), exp_flg(4'h8)});
    end
  endtask

  // Pop of B and push of D land on the same edge with two entries queued.
  task automatic test_same_edge();
    logic [3:0] ops [4] = '{4'h9, 4'hA, 4'hD, 4'hE};
    logic [7:0] opds[4] = '{8'h81, 8'h82, 8'h83, 8'h84};
    clear_mon();
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(ops[i], opds[i]);
    repeat (4) @(negedge clk);
    checks++; if (fifo_count !== 3'd2 || bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL same_pre got=%0d/%b exp=2/1", fifo_count, bus.rsp_valid); end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = ops[3]; bus.cmd_operand = opds[3];
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL same_count got=%0d exp=2", fifo_count); end
    wait_rsp(4);
    for (int i = 0; i < 4 && i < rsp_q.size(); i++) begin
      checks++;
      if (rsp_q[i] !== {ops[i], exp_res(ops[i], opds[i]), exp_flg(ops[i])}) begin
        errors++;
        $display("FAIL same_rsp%0d got=%0h exp=%0h", i, rsp_q[i], {ops[i], exp_res(ops[i], opds[i]), exp_flg(ops[i])});
      end
    end
  endtask

  task automatic test_reset_mid();
    int go_base;
    clear_mon();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 4'h3; bus.cmd_operand = 8'h11;
    @(posedge clk); #1;
    bus.cmd_op = 4'h4; bus.cmd_operand = 8'h22;
    @(posedge clk); #1;
    bus.cmd_op = 4'h5; bus.cmd_operand = 8'h33;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (fifo_count !== 3'd2 || calc_go !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_pre got=%0d/%b/%b exp=2/0/0", fifo_count, calc_go, bus.rsp_valid); end
    rst = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got=%b exp=1", bus.cmd_ready); end
    @(posedge clk); #1 rst = 1'b0;
    go_base = go_count;
    repeat (12) @(negedge clk);
    checks++; if (go_count != go_base) begin errors++; $display("FAIL mid_go_after got=%0d exp=%0d", go_count, go_base); end
    checks++; if (rsp_q.size() != 0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got=%0d/%b exp=0/0", rsp_q.size(), bus.rsp_valid); end
  endtask

  task automatic test_go_protocol();
    checks++;
    if (go_double != 0) begin errors++; $display("FAIL go_consecutive got=%0d exp=0", go_double); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_bad_op();
    test_same_edge();
    test_reset_mid();
    test_go_protocol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
